// File: rtl/btn_debounce_pulse.sv
// btn_debounce_pulse
//   Conditions raw push-button levels into clean load strobes for the ALU
//   front-end. Each button goes through a 2-FF synchronizer, a debounce FSM
//   and a press-edge detector. Qualified presses are queued in a pending
//   mask and issued one per cycle, lowest index first, as a one-hot,
//   one-cycle strobe.
//
// Ports
//   clk          in   1       system clock, rising edge
//   i_rst_n      in   1       asynchronous active-low reset
//   i_btn_raw    in   NB_BTN  raw asynchronous button levels, 1 = pressed
//   o_btn_pulse  out  NB_BTN  one-hot, one-cycle press strobe
//   o_btn_level  out  NB_BTN  debounced level (PRESSED or RELEASE_CNT)
//   o_busy       out  1       at least one press strobe pending, not issued
//
// Debug visibility: state_q[] (one debounce FSM per button) and pending_q
// hold the complete control state and are meant to be bound to checkers.
module btn_debounce_pulse #(
  parameter int NB_BTN          = 3,
  parameter int NB_CNT          = 20,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic [NB_BTN-1:0] i_btn_raw,
  output logic [NB_BTN-1:0] o_btn_pulse,
  output logic [NB_BTN-1:0] o_btn_level,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CNT   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CNT = 2'd3
  } state_e;

  // Terminal count: a level must be seen on DEBOUNCE_CYCLES consecutive
  // cycles inside a *_CNT state before it is accepted.
  localparam logic [NB_CNT-1:0] CNT_MAX = NB_CNT'(DEBOUNCE_CYCLES - 1);

  logic [NB_BTN-1:0] sync1_q;
  logic [NB_BTN-1:0] sync2_q;

  state_e            state_q [NB_BTN];
  state_e            state_d [NB_BTN];
  logic [NB_CNT-1:0] cnt_q   [NB_BTN];
  logic [NB_CNT-1:0] cnt_d   [NB_BTN];

  logic [NB_BTN-1:0] qual_w;      // press qualified this cycle
  logic [NB_BTN-1:0] level_w;
  logic [NB_BTN-1:0] pending_q;
  logic [NB_BTN-1:0] pending_d;
  logic [NB_BTN-1:0] pulse_q;
  logic [NB_BTN-1:0] pulse_d;
  logic              busy_q;

  // Synchronizer and debounce state registers
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      for (int i = 0; i < NB_BTN; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q <= i_btn_raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < NB_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Per-button debounce FSM next state. Only the press qualification
  // (PRESS_CNT -> PRESSED) raises qual_w; release debounce never strobes.
  always_comb begin
    qual_w  = '0;
    level_w = '0;
    for (int i = 0; i < NB_BTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        IDLE: begin
          if (sync2_q[i]) begin
            state_d[i] = PRESS_CNT;
            cnt_d[i]   = '0;
          end
        end
        PRESS_CNT: begin
          if (!sync2_q[i]) begin
            state_d[i] = IDLE;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i] = PRESSED;
            qual_w[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + NB_CNT'(1);
          end
        end
        PRESSED: begin
          level_w[i] = 1'b1;
          if (!sync2_q[i]) begin
            state_d[i] = RELEASE_CNT;
            cnt_d[i]   = '0;
          end
        end
        RELEASE_CNT: begin
          level_w[i] = 1'b1;
          if (sync2_q[i]) begin
            state_d[i] = PRESSED;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i] = IDLE;
          end else begin
            cnt_d[i] = cnt_q[i] + NB_CNT'(1);
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Issue stage: x & -x isolates the lowest set pending bit. New
  // qualifications are OR-ed in before the issued bit is cleared, so a bit
  // that re-qualifies while still pending merges into a single strobe.
  always_comb begin
    pulse_d   = pending_q & (~pending_q + NB_BTN'(1));
    pending_d = (pending_q | qual_w) & ~pulse_d;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending_q <= '0;
      pulse_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      pulse_q   <= pulse_d;
      busy_q    <= |pending_d;
    end
  end

  assign o_btn_pulse = pulse_q;
  assign o_btn_level = level_w;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// tb_btn_debounce_pulse
//   Directed scenarios followed by random button activity. The reference
//   model tracks, per button, the run length of synchronized samples that
//   disagree with the debounced level; DEBOUNCE_CYCLES+1 such samples flip
//   the level, and a 0->1 flip queues a strobe in a pending mask that
//   releases its lowest set bit one cycle later.
module tb_btn_debounce_pulse;

  localparam int NB  = 3;
  localparam int NBC = 3;
  localparam int DB  = 4;

  // ---------------- clock / reset ----------------
  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] raw   = '0;
  logic [NB-1:0] pulse;
  logic [NB-1:0] level;
  logic          busy;

  always #5 clk = ~clk;

  btn_debounce_pulse #(
    .NB_BTN         (NB),
    .NB_CNT         (NBC),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk        (clk),
    .i_rst_n    (rst_n),
    .i_btn_raw  (raw),
    .o_btn_pulse(pulse),
    .o_btn_level(level),
    .o_busy     (busy)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;

  logic [NB-1:0] exp_q[$];
  logic [NB-1:0] s1_m, s2_m, lvl_m, pend_m;
  logic          exp_busy;
  int            run_m [NB];

  // observation of the DUT for directed scenario checks
  int            edge_no;
  int            pcnt  [NB];
  int            pedge [NB];
  logic [NB-1:0] lseen;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    assert (act === exp_v) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, act, exp_v);
    end
  endtask

  task automatic model_reset();
    s1_m     = '0;
    s2_m     = '0;
    lvl_m    = '0;
    pend_m   = '0;
    exp_busy = 1'b0;
    for (int i = 0; i < NB; i++) run_m[i] = 0;
    exp_q.delete();
  endtask

  // One clock edge of the reference model; raw is the value sampled.
  task automatic model_edge();
    logic [NB-1:0] issue;
    logic [NB-1:0] newly;
    issue = '0;
    newly = '0;
    for (int i = 0; i < NB; i++) begin
      if (pend_m[i] && issue == '0) issue[i] = 1'b1;
    end
    for (int i = 0; i < NB; i++) begin
      if (s2_m[i] != lvl_m[i]) begin
        run_m[i]++;
        if (run_m[i] == DB + 1) begin
          lvl_m[i] = ~lvl_m[i];
          run_m[i] = 0;
          if (lvl_m[i]) newly[i] = 1'b1;
        end
      end else begin
        run_m[i] = 0;
      end
    end
    pend_m   = (pend_m | newly) & ~issue;
    exp_busy = (pend_m != '0);
    exp_q.push_back(issue);
    s2_m = s1_m;
    s1_m = raw;
  endtask

  task automatic clear_obs();
    edge_no = 0;
    lseen   = '0;
    for (int i = 0; i < NB; i++) begin
      pcnt[i]  = 0;
      pedge[i] = -1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic [NB-1:0] v);
    logic [NB-1:0] e;
    @(negedge clk);
    raw = v;
    @(posedge clk);
    model_edge();
    #1;
    e = exp_q.pop_front();
    chk("pulse", 32'(pulse), 32'(e));
    chk("level", 32'(level), 32'(lvl_m));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("onehot", 32'($onehot0(pulse)), 32'd1);
    for (int i = 0; i < NB; i++) begin
      if (pulse[i]) begin
        pcnt[i]++;
        pedge[i] = edge_no;
      end
      if (level[i]) lseen[i] = 1'b1;
    end
    edge_no++;
  endtask

  task automatic hold(input logic [NB-1:0] v, input int n);
    for (int k = 0; k < n; k++) step(v);
  endtask

  // Asserts reset mid-cycle, checks outputs clear immediately, releases
  // just after a rising edge so the next edge is the first normal sample.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_pulse", 32'(pulse), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [NB-1:0] rv;
  int            hcnt [NB];

  initial begin
    model_reset();
    clear_obs();
    #2;
    chk("init_pulse", 32'(pulse), 32'd0);
    chk("init_level", 32'(level), 32'd0);
    chk("init_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: single press of A, strobe 7 edges after the first sample
    clear_obs();
    hold(3'b001, 20);
    hold(3'b000, 12);
    chk("t1_count", 32'(pcnt[0]), 32'd1);
    chk("t1_edge", 32'(pedge[0]), 32'd7);
    chk("t1_level_off", 32'(level), 32'd0);

    // 2: short pulse on B is filtered
    clear_obs();
    hold(3'b010, 3);
    hold(3'b000, 12);
    chk("t2_count", 32'(pcnt[1]), 32'd0);
    chk("t2_level", 32'(lseen[1]), 32'd0);

    // 3: bouncing B, last rise sampled at edge 4
    clear_obs();
    step(3'b010); step(3'b000); step(3'b010); step(3'b000);
    hold(3'b010, 16);
    hold(3'b000, 12);
    chk("t3_count", 32'(pcnt[1]), 32'd1);
    chk("t3_edge", 32'(pedge[1]), 32'd11);

    // 4: all three together, issued in index order
    clear_obs();
    hold(3'b111, 15);
    hold(3'b000, 12);
    for (int i = 0; i < NB; i++) begin
      chk("t4_count", 32'(pcnt[i]), 32'd1);
      chk("t4_edge", 32'(pedge[i]), 32'(7 + i));
    end

    // 5: op button bounces back during release debounce
    clear_obs();
    hold(3'b100, 12);
    hold(3'b000, 2);
    hold(3'b100, 10);
    hold(3'b000, 12);
    chk("t5_count", 32'(pcnt[2]), 32'd1);

    // 6: reset mid-count of A while B is held and debounced
    clear_obs();
    hold(3'b010, 10);
    hold(3'b011, 5);
    chk("t6_level_pre", 32'(level), 32'b010);
    async_reset();
    clear_obs();
    hold(3'b011, 15);
    chk("t6_edge_a", 32'(pedge[0]), 32'd7);
    chk("t6_edge_b", 32'(pedge[1]), 32'd8);
    hold(3'b000, 12);

    // random activity: hold lengths straddle the debounce interval
    rv = '0;
    for (int i = 0; i < NB; i++) hcnt[i] = 0;
    for (int t = 0; t < 600; t++) begin
      for (int i = 0; i < NB; i++) begin
        if (hcnt[i] == 0) begin
          rv[i]   = 1'($urandom_range(0, 1));
          hcnt[i] = $urandom_range(1, 10);
        end
        hcnt[i]--;
      end
      step(rv);
      if (t == 300) async_reset();
    end
    hold(3'b000, 12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
